// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key-control state encoding and timing defaults
package key_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } key_state_t;

    localparam int unsigned KEY_CNT_W         = 24;
    localparam logic [23:0] KEY_LONG_CYCLES   = 24'd5_000_000;
    localparam logic [23:0] KEY_REPEAT_CYCLES = 24'd1_000_000;

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - two-flop level register with rise/fall strobes
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s0;
    logic s1;

    // Delay line: s0 is the sampled level, s1 the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= d;
            s1 <= s0;
        end
    end

    assign rise = s0 & ~s1;
    assign fall = ~s0 & s1;

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - press/release/click/long/repeat event pulses from a debounced key
module key_event_gen
    import key_pkg::*;
#(
    parameter bit               ACTIVE_LOW    = 1'b0,
    parameter int unsigned      CNT_W         = KEY_CNT_W,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = CNT_W'(KEY_LONG_CYCLES),
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = CNT_W'(KEY_REPEAT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       key_held,
    output logic [7:0] press_count
);

    // Terminal values: the counter is cleared on entry, so it matches at N-1
    localparam logic [CNT_W-1:0] LONG_TC   = LONG_CYCLES - CNT_W'(1);
    localparam logic [CNT_W-1:0] REPEAT_TC = REPEAT_CYCLES - CNT_W'(1);

    logic k;
    logic rise;
    logic fall;

    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [7:0]       count_d;
    logic             press_d;
    logic             release_d;
    logic             click_d;
    logic             long_d;
    logic             repeat_d;

    assign k = key_in ^ ACTIVE_LOW;

    key_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (k),
        .rise (rise),
        .fall (fall)
    );

    // Next state, hold counter and event decode; a fall beats any terminal count
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = press_count;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SHORT;
                    hold_d  = '0;
                    press_d = 1'b1;
                    count_d = press_count + 8'd1;
                end
            end
            SHORT: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (hold_q == LONG_TC) begin
                    state_d = LONG;
                    hold_d  = '0;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (hold_q == REPEAT_TC) begin
                    hold_d   = '0;
                    repeat_d = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            press_count   <= 8'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            press_count   <= count_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            click_pulse   <= click_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            key_held      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed self-checking bench for key_event_gen
module tb_key_event_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       key_al;

    logic       press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, key_held;
    logic [7:0] press_count;
    logic       press_al, release_al, click_al, long_al, repeat_al, held_al;
    logic [7:0] count_al;

    int checks = 0;
    int errors = 0;
    int n_press, n_release, n_click, n_long, n_repeat;
    int n_press_al, n_click_al;

    always #5 clk = ~clk;

    key_event_gen #(
        .ACTIVE_LOW    (1'b0),
        .CNT_W         (24),
        .LONG_CYCLES   (24'd10),
        .REPEAT_CYCLES (24'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .key_held      (key_held),
        .press_count   (press_count)
    );

    key_event_gen #(
        .ACTIVE_LOW    (1'b1),
        .CNT_W         (24),
        .LONG_CYCLES   (24'd10),
        .REPEAT_CYCLES (24'd4)
    ) dut_al (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_al),
        .press_pulse   (press_al),
        .release_pulse (release_al),
        .click_pulse   (click_al),
        .long_pulse    (long_al),
        .repeat_pulse  (repeat_al),
        .key_held      (held_al),
        .press_count   (count_al)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (press_pulse)   n_press++;
        if (release_pulse) n_release++;
        if (click_pulse)   n_click++;
        if (long_pulse)    n_long++;
        if (repeat_pulse)  n_repeat++;
        if (press_al)      n_press_al++;
        if (click_al)      n_click_al++;
    endtask

    task automatic clear_tally();
        n_press = 0; n_release = 0; n_click = 0; n_long = 0; n_repeat = 0;
    endtask

    task automatic scen_click(input bit use_al);
        logic p, r, c, l, rp, h;
        logic [7:0] cnt;
        if (use_al) key_al = 1'b0; else key = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            cyc();
            p   = use_al ? press_al   : press_pulse;
            r   = use_al ? release_al : release_pulse;
            c   = use_al ? click_al   : click_pulse;
            l   = use_al ? long_al    : long_pulse;
            rp  = use_al ? repeat_al  : repeat_pulse;
            h   = use_al ? held_al    : key_held;
            cnt = use_al ? count_al   : press_count;
            chk("click_press", 32'(p), 32'(j == 2));
            chk("click_release", 32'(r), 32'(j == 7));
            chk("click_click", 32'(c), 32'(j == 7));
            chk("click_long", 32'(l), 32'd0);
            chk("click_repeat", 32'(rp), 32'd0);
            chk("click_held", 32'(h), 32'(j >= 2 && j < 7));
            if (j == 2) chk("click_count", 32'(cnt), 32'd1);
            if (j == 5) begin
                if (use_al) key_al = 1'b1; else key = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; key = 1'b0; key_al = 1'b1;
        clear_tally(); n_press_al = 0; n_click_al = 0;

        // Reset state
        repeat (3) cyc();
        chk("rst_press", 32'(press_pulse), 32'd0);
        chk("rst_release", 32'(release_pulse), 32'd0);
        chk("rst_click", 32'(click_pulse), 32'd0);
        chk("rst_long", 32'(long_pulse), 32'd0);
        chk("rst_repeat", 32'(repeat_pulse), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        chk("rst_al_held", 32'(held_al), 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Scenario 1: short press of 5 cycles
        scen_click(1'b0);
        chk("s1_no_long", 32'(n_long), 32'd0);
        repeat (3) cyc();

        // Scenario 2: 25-cycle hold with long and repeats
        key = 1'b1;
        cyc();
        for (int k = 0; k <= 30; k++) begin
            cyc();
            chk("hold_press", 32'(press_pulse), 32'(k == 0));
            chk("hold_long", 32'(long_pulse), 32'(k == 10));
            chk("hold_repeat", 32'(repeat_pulse), 32'(k == 14 || k == 18 || k == 22));
            chk("hold_release", 32'(release_pulse), 32'(k == 25));
            chk("hold_click", 32'(click_pulse), 32'd0);
            if (k == 0) chk("hold_count", 32'(press_count), 32'd2);
            if (k == 23) key = 1'b0;
        end

        // Scenario 3: release lands on the long terminal cycle
        key = 1'b1;
        cyc();
        for (int k = 0; k <= 14; k++) begin
            cyc();
            chk("tie_long", 32'(long_pulse), 32'd0);
            chk("tie_release", 32'(release_pulse), 32'(k == 10));
            chk("tie_click", 32'(click_pulse), 32'(k == 10));
            if (k == 0) chk("tie_count", 32'(press_count), 32'd3);
            if (k == 8) key = 1'b0;
        end

        // Scenario 4: 256 short presses wrap the counter
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("wrap_start", 32'(press_count), 32'd0);
        clear_tally();
        for (int i = 0; i < 256; i++) begin
            key = 1'b1;
            repeat (4) cyc();
            key = 1'b0;
            repeat (4) cyc();
            if (i == 254) chk("wrap_255", 32'(press_count), 32'd255);
        end
        repeat (3) cyc();
        chk("wrap_0", 32'(press_count), 32'd0);
        chk("wrap_n_press", 32'(n_press), 32'd256);
        chk("wrap_n_release", 32'(n_release), 32'd256);
        chk("wrap_n_click", 32'(n_click), 32'd256);
        chk("wrap_n_long", 32'(n_long), 32'd0);

        // Scenario 5: reset during a LONG hold with the key kept pressed
        key = 1'b1;
        cyc();
        repeat (14) cyc();
        chk("mid_held", 32'(key_held), 32'd1);
        clear_tally();
        rst = 1'b1;
        cyc();
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_count", 32'(press_count), 32'd0);
        chk("mid_rst_pulses", 32'({press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse}), 32'd0);
        rst = 1'b0;
        cyc();
        chk("mid_after_held", 32'(key_held), 32'd0);
        chk("mid_after_pulses", 32'({press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse}), 32'd0);
        cyc();
        chk("mid_press", 32'(press_pulse), 32'd1);
        chk("mid_count", 32'(press_count), 32'd1);
        chk("mid_held2", 32'(key_held), 32'd1);
        chk("mid_no_release", 32'(n_release), 32'd0);
        key = 1'b0;
        repeat (4) cyc();

        // Scenario 6: active-low instance, same timing as scenario 1
        scen_click(1'b1);
        repeat (2) cyc();
        chk("al_n_press", 32'(n_press_al), 32'd1);
        chk("al_n_click", 32'(n_click_al), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
